// File: rtl/counter_nbit_updown_if.sv
// Control and status bundle for counter_nbit_updown: the master drives the
// control strobes, and the slave returns the count and its flags.
interface counter_nbit_updown_if #(
  parameter int WIDTH = 8
);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             up;
  logic [WIDTH-1:0] cnt;
  logic             tc;
  logic             wrap;
  logic             ovf;

  modport master (
    output clr, load, load_val, en, up,
    input  cnt, tc, wrap, ovf
  );

  modport slave (
    input  clr, load, load_val, en, up,
    output cnt, tc, wrap, ovf
  );
endinterface

// File: rtl/counter_nbit_updown.sv
// WIDTH-bit up/down counter with a programmable modulus and a choice of wrap or
// saturate at the range ends. It flags terminal count, a wrap pulse and a sticky overflow.
module counter_nbit_updown #(
  parameter int              WIDTH    = 8,
  parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
  parameter bit              SATURATE = 1'b0
) (
  input  logic                clk,
  input  logic                res,
  counter_nbit_updown_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] inc_s, dec_s;
  logic             at_max_s, at_zero_s, load_oor_s;

  assign at_max_s   = (cnt_q == MAX_C);
  assign at_zero_s  = (cnt_q == {WIDTH{1'b0}});
  assign load_oor_s = (64'(bus.load_val) >= MODULUS);

  // Ripple half-adder (carry) and half-subtractor (borrow) chains, one stage per bit
  always_comb begin
    logic carry_v;
    logic borrow_v;
    carry_v  = 1'b1;
    borrow_v = 1'b1;
    inc_s    = {WIDTH{1'b0}};
    dec_s    = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      inc_s[i] = cnt_q[i] ^ carry_v;
      dec_s[i] = cnt_q[i] ^ borrow_v;
      carry_v  = cnt_q[i] & carry_v;
      borrow_v = ~cnt_q[i] & borrow_v;
    end
  end

  // Next-state selection in priority order: clear, load, count
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    ovf_d  = ovf_q;
    if (bus.clr) begin
      cnt_d = {WIDTH{1'b0}};
      ovf_d = 1'b0;
    end else if (bus.load) begin
      if (load_oor_s) begin
        cnt_d = MAX_C;
        ovf_d = 1'b1;
      end else begin
        cnt_d = bus.load_val;
      end
    end else if (bus.en) begin
      case (bus.up)
        1'b1: begin
          if (at_max_s) begin
            ovf_d = 1'b1;
            if (SATURATE) begin
              cnt_d = cnt_q;
            end else begin
              cnt_d  = {WIDTH{1'b0}};
              wrap_d = 1'b1;
            end
          end else begin
            cnt_d = inc_s;
          end
        end
        1'b0: begin
          if (at_zero_s) begin
            ovf_d = 1'b1;
            if (SATURATE) begin
              cnt_d = cnt_q;
            end else begin
              cnt_d  = MAX_C;
              wrap_d = 1'b1;
            end
          end else begin
            cnt_d = dec_s;
          end
        end
        default: begin
          cnt_d = cnt_q;
        end
      endcase
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (res) begin
      cnt_q  <= {WIDTH{1'b0}};
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.cnt  = cnt_q;
  assign bus.wrap = wrap_q;
  assign bus.ovf  = ovf_q;
  assign bus.tc   = bus.en & ((bus.up & at_max_s) | (~bus.up & at_zero_s));
endmodule

// File: tb/tb_counter_nbit_updown.sv
// Three counter configurations share one stimulus stream. Each cycle, an
// arithmetic reference model pushes the expected results into a scoreboard.
module tb_counter_nbit_updown;
  logic clk = 1'b0;
  logic res = 1'b1;
  always #5 clk = ~clk;

  counter_nbit_updown_if #(.WIDTH(4)) ifa ();
  counter_nbit_updown_if #(.WIDTH(4)) ifb ();
  counter_nbit_updown_if #(.WIDTH(8)) ifc ();

  counter_nbit_updown #(.WIDTH(4), .MODULUS(64'd10), .SATURATE(1'b0)) dut_a (.clk(clk), .res(res), .bus(ifa));
  counter_nbit_updown #(.WIDTH(4), .MODULUS(64'd10), .SATURATE(1'b1)) dut_b (.clk(clk), .res(res), .bus(ifb));
  counter_nbit_updown #(.WIDTH(8), .MODULUS(64'd256), .SATURATE(1'b0)) dut_c (.clk(clk), .res(res), .bus(ifc));

  typedef struct packed {
    logic        tc_chk;
    logic [2:0]  tc;
    logic [2:0]  wrap;
    logic [2:0]  ovf;
    logic [23:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  bit   busy     = 1'b0;
  bit   known    = 1'b0;

  int mods[3] = '{10, 10, 256};
  bit sats[3] = '{1'b0, 1'b1, 1'b0};
  int m_cnt[3];
  bit m_wrap[3];
  bit m_ovf[3];

  logic [2:0]  act_tc, act_wrap, act_ovf;
  logic [23:0] act_cnt;
  assign act_tc   = {ifc.tc, ifb.tc, ifa.tc};
  assign act_wrap = {ifc.wrap, ifb.wrap, ifa.wrap};
  assign act_ovf  = {ifc.ovf, ifb.ovf, ifa.ovf};
  assign act_cnt  = {ifc.cnt, {4'b0000, ifb.cnt}, {4'b0000, ifa.cnt}};

  task automatic chk(input string nm, input int i, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d @%0t: got %0d expected %0d", nm, i, $time, act, exp);
    end
  endtask

  // One cycle of stimulus: apply the inputs, then advance the reference model
  task automatic step(input bit r, input bit c, input bit l, input int lv, input bit e, input bit u);
    exp_t x;
    @(negedge clk);
    res = r;
    ifa.clr = c; ifb.clr = c; ifc.clr = c;
    ifa.load = l; ifb.load = l; ifc.load = l;
    ifa.load_val = 4'(lv); ifb.load_val = 4'(lv); ifc.load_val = 8'(lv);
    ifa.en = e; ifb.en = e; ifc.en = e;
    ifa.up = u; ifb.up = u; ifc.up = u;
    x = '0;
    x.tc_chk = known;
    for (int i = 0; i < 3; i++) begin
      int lve;
      int t;
      lve = (i == 2) ? (lv & 255) : (lv & 15);
      x.tc[i] = e && ((u && m_cnt[i] == mods[i] - 1) || (!u && m_cnt[i] == 0));
      m_wrap[i] = 1'b0;
      if (r) begin
        m_cnt[i] = 0;
        m_ovf[i] = 1'b0;
      end else if (c) begin
        m_cnt[i] = 0;
        m_ovf[i] = 1'b0;
      end else if (l) begin
        if (lve >= mods[i]) begin
          m_cnt[i] = mods[i] - 1;
          m_ovf[i] = 1'b1;
        end else begin
          m_cnt[i] = lve;
        end
      end else if (e) begin
        t = m_cnt[i] + (u ? 1 : -1);
        if (t < 0 || t >= mods[i]) begin
          m_ovf[i] = 1'b1;
          if (sats[i]) begin
            t = m_cnt[i];
          end else begin
            t = (t + mods[i]) % mods[i];
            m_wrap[i] = 1'b1;
          end
        end
        m_cnt[i] = t;
      end
      x.cnt[8*i +: 8] = 8'(m_cnt[i]);
      x.wrap[i] = m_wrap[i];
      x.ovf[i]  = m_ovf[i];
    end
    if (r) known = 1'b1;
    sb_q.push_back(x);
  endtask

  // Monitor: check tc before the edge and the registered outputs after it
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #3;
      if (sb_q.size() != 0) begin
        x = sb_q.pop_front();
        busy = 1'b1;
        if (x.tc_chk) begin
          for (int i = 0; i < 3; i++) chk("tc", i, 8'(act_tc[i]), 8'(x.tc[i]));
        end
        @(posedge clk);
        #2;
        for (int i = 0; i < 3; i++) begin
          chk("cnt", i, act_cnt[8*i +: 8], x.cnt[8*i +: 8]);
          chk("wrap", i, 8'(act_wrap[i]), 8'(x.wrap[i]));
          chk("ovf", i, 8'(act_ovf[i]), 8'(x.ovf[i]));
        end
        busy = 1'b0;
      end
    end
  end

  initial begin
    int guard;
    ifa.clr = 1'b0; ifb.clr = 1'b0; ifc.clr = 1'b0;
    ifa.load = 1'b0; ifb.load = 1'b0; ifc.load = 1'b0;
    ifa.load_val = 4'd0; ifb.load_val = 4'd0; ifc.load_val = 8'd0;
    ifa.en = 1'b0; ifb.en = 1'b0; ifc.en = 1'b0;
    ifa.up = 1'b1; ifb.up = 1'b1; ifc.up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_wrap[i] = 1'b0; m_ovf[i] = 1'b0;
    end

    repeat (2) step(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    repeat (12) step(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 3, 1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    repeat (12) step(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
    repeat (2) step(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 12, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 5, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 6, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 9, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 255, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 9, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1);

    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 10,
           int'($urandom_range(0, 255)), $urandom_range(0, 99) < 75, 1'($urandom()));
    end

    guard = 0;
    while ((sb_q.size() != 0 || busy) && guard < 20) begin
      @(posedge clk);
      #4;
      guard++;
    end
    n_checks++;
    if (sb_q.size() != 0 || busy) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
